// File: rtl/brightness_pkg.sv
// ==================================================================
// Package  : brightness_pkg
// Shared scheduler state type and BPM width helper.
// Revision : 1.0
// ==================================================================
`default_nettype none

package brightness_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      ARM   = 2'd1,
      TRACK = 2'd2,
      FADE  = 2'd3
   } sched_state_t;

   function automatic int bpm_width(input int max_bpm);
      return $clog2(max_bpm + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bpm_slew_limiter.sv
// ==================================================================
// Module   : bpm_slew_limiter
// Combinational one-frame step of a value toward a goal, bounded by RAMP_STEP.
// Revision : 1.0
// ==================================================================
`default_nettype none

module bpm_slew_limiter #(
   parameter int W         = 8,
   parameter int RAMP_STEP = 4
) (
   input  logic [W-1:0] current,
   input  logic [W-1:0] goal,
   output logic [W-1:0] next_value
);

   localparam logic [W:0]   c_step   = (W+1)'(RAMP_STEP);
   localparam logic [W-1:0] c_step_w = W'(RAMP_STEP);

   logic         w_up;
   logic [W:0]   w_diff;
   logic [W-1:0] w_step;

   // The distance is taken one bit wider so it can never wrap.
   always_comb begin
      w_up   = (goal >= current);
      w_diff = w_up ? ({1'b0, goal} - {1'b0, current})
                    : ({1'b0, current} - {1'b0, goal});
      w_step = (w_diff < c_step) ? w_diff[W-1:0] : c_step_w;
      next_value = w_up ? (current + w_step) : (current - w_step);
   end

endmodule

`default_nettype wire

// File: rtl/brightness_scheduler.sv
// ==================================================================
// Module   : brightness_scheduler
// Frame-synchronous enable/BPM controller feeding brightness_filter.
// Revision : 1.0
// ==================================================================
`default_nettype none

module brightness_scheduler
   import brightness_pkg::*;
#(
   parameter int MAX_BPM        = 200,
   parameter int RAMP_STEP      = 4,
   parameter int TIMEOUT_FRAMES = 30,
   localparam int W             = bpm_width(MAX_BPM)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] bpm_in,
   input  logic         bpm_valid,
   output logic         bpm_ready,
   input  logic         enable_req,
   input  logic         sof,
   output logic         filter_enable,
   output logic [W-1:0] BPM_estimate,
   output logic         busy
);

   localparam int              c_sw      = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [c_sw-1:0] c_timeout = c_sw'(TIMEOUT_FRAMES);
   localparam logic [W-1:0]    c_max     = W'(MAX_BPM);

   sched_state_t    r_state;
   sched_state_t    w_next_state;
   logic [W-1:0]    r_target;
   logic [W-1:0]    r_current;
   logic [c_sw-1:0] r_stale;
   logic            r_fen;
   logic            r_ready;
   logic            r_busy;

   logic [W-1:0]    w_goal;
   logic [W-1:0]    w_slewed;
   logic [W-1:0]    w_bpm_clamped;
   logic            w_accept;
   logic            w_stale_hit;
   logic            w_ramp;
   logic            w_arm_to_track;
   logic            w_fade_to_off;

   bpm_slew_limiter #(
      .W         (W),
      .RAMP_STEP (RAMP_STEP)
   ) u_slew (
      .current    (r_current),
      .goal       (w_goal),
      .next_value (w_slewed)
   );

   always_comb begin
      w_accept      = bpm_valid && r_ready;
      w_bpm_clamped = (bpm_in > c_max) ? c_max : bpm_in;
      w_stale_hit   = (r_stale == c_timeout);
      // One limiter serves both the tracking ramp and the fade to zero.
      w_goal        = (r_state == FADE) ? '0 : r_target;
      w_next_state  = r_state;
      w_ramp        = 1'b0;
      case (r_state)
         OFF: begin
            if (enable_req) w_next_state = ARM;
         end
         ARM: begin
            if (!enable_req)  w_next_state = OFF;
            else if (sof)     w_next_state = TRACK;
         end
         TRACK: begin
            w_ramp = sof;
            if (!enable_req || w_stale_hit) w_next_state = FADE;
         end
         FADE: begin
            if (sof) begin
               if (r_current == '0)                  w_next_state = OFF;
               else if (enable_req && !w_stale_hit)  w_next_state = TRACK;
               else                                  w_ramp = 1'b1;
            end
         end
         default: w_next_state = OFF;
      endcase
      w_arm_to_track = (r_state == ARM)  && (w_next_state == TRACK);
      w_fade_to_off  = (r_state == FADE) && (w_next_state == OFF);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= OFF;
         r_target  <= '0;
         r_current <= '0;
         r_stale   <= '0;
         r_fen     <= 1'b0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_ready <= (w_next_state != FADE);
         r_busy  <= (w_next_state != OFF);

         if (w_ramp) r_current <= w_slewed;

         if (w_arm_to_track)     r_fen <= 1'b1;
         else if (w_fade_to_off) r_fen <= 1'b0;

         if (w_accept) r_target <= w_bpm_clamped;

         // An accept in the same cycle as a frame tick clears the count.
         if (w_accept || w_arm_to_track)
            r_stale <= '0;
         else if ((r_state == TRACK) && sof && !w_stale_hit)
            r_stale <= r_stale + c_sw'(1);
      end
   end

   assign bpm_ready     = r_ready;
   assign busy          = r_busy;
   assign filter_enable = r_fen;
   assign BPM_estimate  = r_current;

endmodule

`default_nettype wire

// File: doc/brightness_scheduler.md
# brightness_scheduler

Frame-synchronous controller for `brightness_filter`. It takes BPM estimates from the heart-rate path and the user enable request, and drives the filter's `filter_enable` and `BPM_estimate` inputs. Brightness therefore never changes mid-frame, ramps toward its target with a limited slew, and fades out cleanly on disable or when BPM updates go stale. It sits beside the pixel pipeline and observes only its start-of-frame strobe.

## Interface
Parameters:
- `MAX_BPM`, 200: full-scale BPM. Inputs above this are clamped.
- `RAMP_STEP`, 4: maximum change of `BPM_estimate` per frame.
- `TIMEOUT_FRAMES`, 30: number of frames without an accepted BPM before a forced fade.

Ports (W = $clog2(MAX_BPM+1)):
- `clk` in, 1: sole clock.
- `reset` in, 1: asynchronous, active-high.
- `bpm_in` in, W: new BPM estimate.
- `bpm_valid` in, 1: `bpm_in` is valid.
- `bpm_ready` out, 1: block accepts `bpm_in`.
- `enable_req` in, 1: user request for the filter effect, level-sensitive.
- `sof` in, 1: one-cycle start-of-frame pulse from the pixel stream.
- `filter_enable` out, 1: drives `brightness_filter.filter_enable`.
- `BPM_estimate` out, W: drives `brightness_filter.BPM_estimate`.
- `busy` out, 1: high in ARM, TRACK or FADE.

## Operation
- States: OFF, ARM, TRACK, FADE.
- Internal registers: `target` (W bits), `current` (W bits, equal to the `BPM_estimate` output), `stale_cnt` (counts to TIMEOUT_FRAMES and saturates).
- BPM handshake:
  - An input is accepted when `bpm_valid && bpm_ready`.
  - `bpm_ready` is 1 in OFF, ARM and TRACK, and 0 in FADE and during reset.
  - On accept: `target <= min(bpm_in, MAX_BPM)` and `stale_cnt <= 0`.
- `stale_cnt` increments on each `sof` in TRACK only. If an accept and a `sof` occur in the same cycle, the clear wins.
- OFF: `filter_enable = 0`, `current = 0`. When `enable_req = 1`, go to ARM.
- ARM:
  - `enable_req = 0` → OFF on the next edge.
  - `sof && enable_req` → `filter_enable <= 1`, `stale_cnt <= 0`, go to TRACK. `current` stays 0.
- TRACK, on each `sof`:
  - `current` moves toward `target` by `min(RAMP_STEP, |target - current|)`.
  - The ramp uses the value of `target` before any accept in that same cycle.
  - If `enable_req = 0`, or `stale_cnt` reaches TIMEOUT_FRAMES, go to FADE on the next edge. This exit does not wait for `sof`.
- FADE, on each `sof`:
  - `current <= current - min(RAMP_STEP, current)`.
  - On a `sof` where `current == 0`: `filter_enable <= 0`, go to OFF.
  - On a `sof` where `enable_req = 1` and `stale_cnt < TIMEOUT_FRAMES` (the fade was caused by a user disable): go to TRACK instead. No decrement happens on that frame.
- Arithmetic:
  - All values are unsigned W-bit.
  - Differences are computed W+1 bits wide, so there is no wrap.
  - `current` never goes below 0 and never exceeds MAX_BPM.

## Timing
- All outputs are registered.
- `sof` sampled at edge N → `BPM_estimate` and `filter_enable` change after edge N. This is one cycle of latency, which puts the update before the first pixel of the frame.
- Outside `sof` edges, `current` and `filter_enable` are constant.
- The only state change that needs no `sof` is entering FADE.
- Reset values: `filter_enable = 0`, `BPM_estimate = 0`, `bpm_ready = 0`, `busy = 0`, state OFF, `target = 0`, `stale_cnt = 0`.
- `bpm_ready` rises on the first edge after reset deasserts.
- Reset asserted mid-ramp forces all outputs to their reset values immediately (asynchronous), regardless of `sof`.
- If `sof` and a `bpm_valid` accept arrive in the same cycle, the new target is first seen at the next `sof`.
- `sof` pulses must be at least 2 cycles apart. Behaviour with back-to-back `sof` is undefined.

## Structure
- `brightness_pkg` contains:
  - typedef `sched_state_t` enum {OFF, ARM, TRACK, FADE};
  - function `bpm_width(max_bpm)` returning $clog2(max_bpm+1).
  - `brightness_filter` imports the same width function.
- Sub-module `bpm_slew_limiter`: combinational next-value step given `current`, `goal` and `RAMP_STEP`. It is used by TRACK (goal = `target`) and FADE (goal = 0).

## Test plan
All scenarios use `RAMP_STEP = 4`, `TIMEOUT_FRAMES = 4`, and a `sof` every 20 cycles.
1. Reset: `reset` high mid-stream → all outputs 0 in the same cycle. Release → `bpm_ready = 1` one edge later.
2. Ramp-up: `enable_req = 1`, accept BPM 10, then 4 × `sof` → `filter_enable = 1` after the first `sof`; `BPM_estimate` sequence 0, 4, 8, 10. Values change only on the cycle after each `sof`.
3. Clamp and ramp-down: accept BPM 250 → target 200. Then accept BPM 6 while `current = 12`, same cycle as a `sof` → that frame moves toward the old target. Following frames step 12 → 8 → 6.
4. Disable fade: `enable_req` drops with `current = 9` → FADE with `bpm_ready = 0`. `sof`s give 5, 1, 0. On the `sof` where `current` is 0, `filter_enable` goes to 0 and state is OFF.
5. Re-enable during fade: drop `enable_req` at `current = 20`, raise it again before the second `sof` → returns to TRACK, `filter_enable` never drops.
6. Timeout: in TRACK, 4 `sof`s with no `bpm_valid` → FADE to 0 and OFF, even with `enable_req = 1`. A `bpm_valid` accept just before the 4th `sof` clears the count and keeps TRACK.
